// File: rtl/alu_pkg.sv
// Shared opcode encoding and default operand width for the ALU slice.
package alu_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_NOT = 3'd6,
    OP_DIV = 3'd7
  } opcode_e;
endpackage

// File: rtl/alu_core_if.sv
// Operand/result bundle between a requester (master) and the ALU (slave).
interface alu_core_if import alu_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic               in_valid;
  logic [2:0]         sel;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] out;
  logic               out_valid;
  logic               zero;
  logic               div_by_zero;

  modport master (output in_valid, sel, a, b,
                  input  out, out_valid, zero, div_by_zero);
  modport slave  (input  in_valid, sel, a, b,
                  output out, out_valid, zero, div_by_zero);
endinterface

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider, one compare/subtract stage per quotient bit.
module alu_divider #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);
  logic [WIDTH:0] trial;

  assign div_by_zero = (b == '0);

  // Partial remainder never exceeds b-1, so WIDTH+1 bits hold the shifted trial value.
  always_comb begin
    quo   = '0;
    rem   = '0;
    trial = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      trial = {rem, a[i]};
      if (trial >= {1'b0, b}) begin
        trial  = trial - {1'b0, b};
        quo[i] = 1'b1;
      end
      rem = trial[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/alu_core.sv
// Single-cycle 8-op ALU; result, zero and divide-by-zero flags registered one clock after in_valid.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  alu_core_if.slave bus
);
  localparam int RW = 2*WIDTH;

  logic [RW-1:0]    ax, bx, res;
  logic [WIDTH-1:0] quo, rem;
  logic             dz;
  opcode_e          op;

  assign ax = {{WIDTH{1'b0}}, bus.a};
  assign bx = {{WIDTH{1'b0}}, bus.b};
  assign op = opcode_e'(bus.sel);

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .a           (bus.a),
    .b           (bus.b),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (dz)
  );

  // SUB in RW bits wraps naturally, giving the sign-extended difference.
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_MUL:  res = ax * bx;
      OP_AND:  res = ax & bx;
      OP_OR:   res = ax | bx;
      OP_XOR:  res = ax ^ bx;
      OP_NOT:  res = {{WIDTH{1'b0}}, ~bus.a};
      OP_DIV:  res = dz ? '1 : {rem, quo};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out         <= '0;
      bus.out_valid   <= 1'b0;
      bus.zero        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out         <= res;
        bus.zero        <= (res == '0);
        bus.div_by_zero <= (op == OP_DIV) && dz;
      end
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed tables plus a queued scoreboard for random traffic.
module tb_alu_core;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] out;
    logic       zero;
    logic       dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t last;

  alu_core_if #(.WIDTH(4)) bus ();

  alu_core #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] s, input int x, input int y);
    exp_t e;
    int   r;
    e.dbz = 1'b0;
    case (s)
      3'd0: r = x + y;
      3'd1: r = (x - y) & 255;
      3'd2: r = x * y;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = 15 - x;
      default: begin
        if (y == 0) begin r = 255; e.dbz = 1'b1; end
        else r = (x % y) * 16 + (x / y);
      end
    endcase
    e.out  = r[7:0];
    e.zero = (r == 0);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] x, input logic [3:0] y);
    bus.in_valid = v;
    bus.sel      = s;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 3'd0, 4'd5, 4'd6);
    drive(1'b1, 3'd0, 4'd5, 4'd6);
    checks++;
    if (bus.out !== 8'h00 || bus.out_valid !== 1'b0 || bus.zero !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset got out=%h vld=%b z=%b dbz=%b exp 00/0/0/0",
               bus.out, bus.out_valid, bus.zero, bus.div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] tbl [8] = '{8'h09, 8'hFB, 8'h0E, 8'h02, 8'h07, 8'h05, 8'h0D, 8'h20};
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 3'(s), 4'd2, 4'd7);
      checks++;
      if (bus.out !== tbl[s] || bus.out_valid !== 1'b1 || bus.zero !== 1'b0 || bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL sweep sel=%0d got out=%h vld=%b z=%b dbz=%b exp %h/1/0/0",
                 s, bus.out, bus.out_valid, bus.zero, bus.div_by_zero, tbl[s]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [2:0] ops [5] = '{3'd0, 3'd2, 3'd1, 3'd5, 3'd6};
    logic [7:0] ev  [5] = '{8'h1E, 8'hE1, 8'h00, 8'h00, 8'h00};
    logic       ez  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], 4'd15, 4'd15);
      checks++;
      if (bus.out !== ev[i] || bus.zero !== ez[i] || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL extreme sel=%0d got out=%h z=%b vld=%b exp %h/%b/1",
                 ops[i], bus.out, bus.zero, bus.out_valid, ev[i], ez[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [3:0] da [3] = '{4'd13, 4'd9, 4'd9};
    logic [3:0] db [3] = '{4'd4, 4'd0, 4'd3};
    logic [7:0] ev [3] = '{8'h13, 8'hFF, 8'h03};
    logic       ed [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd7, da[i], db[i]);
      checks++;
      if (bus.out !== ev[i] || bus.div_by_zero !== ed[i] || bus.zero !== 1'b0) begin
        errors++;
        $display("FAIL div a=%0d b=%0d got out=%h dbz=%b z=%b exp %h/%b/0",
                 da[i], db[i], bus.out, bus.div_by_zero, bus.zero, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_handshake();
    drive(1'b1, 3'd0, 4'd3, 4'd4);
    checks++;
    if (bus.out !== 8'h07 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pulse got out=%h vld=%b exp 07/1", bus.out, bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd2, 4'd9, 4'd9);
      checks++;
      if (bus.out !== 8'h07 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d got out=%h vld=%b exp 07/0", i, bus.out, bus.out_valid);
      end
    end
    rst = 1'b1;
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    rst = 1'b0;
    checks++;
    if (bus.out !== 8'h00 || bus.out_valid !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL idle_reset got out=%h vld=%b z=%b exp 00/0/0", bus.out, bus.out_valid, bus.zero);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 3'd7, 4'd9, 4'd0);
    rst = 1'b1;
    drive(1'b1, 3'd0, 4'd5, 4'd5);
    rst = 1'b0;
    checks++;
    if (bus.out !== 8'h00 || bus.out_valid !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got out=%h vld=%b dbz=%b exp 00/0/0", bus.out, bus.out_valid, bus.div_by_zero);
    end
    drive(1'b1, 3'd2, 4'd3, 4'd3);
    checks++;
    if (bus.out !== 8'h09 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_rst got out=%h vld=%b exp 09/1", bus.out, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [2:0] s;
    logic [3:0] x, y;
    exp_t       e;
    rst = 1'b1;
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    rst  = 1'b0;
    last = '0;
    sbq.delete();
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(3) != 0);
      s = 3'($urandom_range(7));
      x = 4'($urandom_range(15));
      y = 4'($urandom_range(15));
      if (v) sbq.push_back(model(s, int'(x), int'(y)));
      drive(v, s, x, y);
      if (v) begin
        e    = sbq.pop_front();
        last = e;
      end else begin
        e = last;
      end
      checks++;
      if (bus.out_valid !== v || bus.out !== e.out || bus.zero !== e.zero || bus.div_by_zero !== e.dbz) begin
        errors++;
        $display("FAIL random i=%0d sel=%0d a=%0d b=%0d got %h/%b/%b/%b exp %h/%b/%b/%b",
                 i, s, x, y, bus.out, bus.out_valid, bus.zero, bus.div_by_zero,
                 e.out, v, e.zero, e.dbz);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.sel      = '0;
    bus.a        = '0;
    bus.b        = '0;
    test_reset();
    test_sweep();
    test_extremes();
    test_div();
    test_handshake();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 4-bit combinational-style ALU with a 3-bit opcode select and an 8-bit result.
- Sits in the datapath as a single-cycle arithmetic/logic unit; the result is registered and tagged valid one clock after the operands are presented.
- Eight operations: add, subtract, multiply, AND, OR, XOR, NOT, divide (quotient/remainder).

Parameters:
- WIDTH, 4, operand width; result width is 2*WIDTH (8 at default). All test values below assume WIDTH=4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/opcode valid this cycle.
- sel  input  3  opcode (encoding below).
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out  output  2*WIDTH  registered result.
- out_valid  output  1  out/flags hold a fresh result.
- zero  output  1  registered result equals 0.
- div_by_zero  output  1  registered flag: last accepted op was DIV with b=0.

Behaviour:
- Reset: on rising clk with rst=1, out=0, out_valid=0, zero=0, div_by_zero=0. rst takes priority over in_valid in the same cycle.
- Latency: 1 cycle. in_valid=1 at edge N loads out/zero/div_by_zero and sets out_valid=1 after edge N.
- in_valid=0 at an edge clears out_valid. out, zero and div_by_zero hold their last values. No backpressure.
- Opcodes (a, b zero-extended to 2*WIDTH unless stated):
  - 0 ADD: a+b. Carry lands in bit WIDTH. Max 15+15=30 (0x1E).
  - 1 SUB: a-b, two's complement, 2*WIDTH bits. Negative results are sign-extended, e.g. 2-7 = 0xFB.
  - 2 MUL: a*b, full 2*WIDTH product. Max 15*15=225 (0xE1).
  - 3 AND: a&b in low WIDTH bits, upper bits 0.
  - 4 OR: a|b in low bits, upper 0.
  - 5 XOR: a^b in low bits, upper 0.
  - 6 NOT: ~a in low bits, upper 0. b ignored.
  - 7 DIV: out = {a % b, a / b}, remainder in the upper WIDTH bits, quotient in the lower.
- DIV with b=0: out = all ones (0xFF), div_by_zero=1. Otherwise div_by_zero=0 on every accepted op.
- zero = (next out == 0). It is evaluated on the same value that is loaded into out.
- Division is combinational: a restoring divider unrolled over WIDTH stages, or the operator. It still meets 1-cycle latency.
- Back-to-back in_valid every cycle is supported. Each result corresponds to the operands of the previous edge.
- Reset asserted mid-stream discards the pending result. The first valid after reset release behaves normally.

Decomposition:
- Shared package alu_pkg:
  - opcode enum: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_NOT=6, OP_DIV=7.
  - default WIDTH constant.
- One natural sub-module: alu_divider, a combinational unsigned WIDTH-bit quotient/remainder unit with a div_by_zero output.
- Output register and flag logic stay in alu_core.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out=0x00, out_valid=0, zero=0, div_by_zero=0.
- Sweep sel=0..7 with a=2, b=7, in_valid=1 each cycle -> out one cycle later = 0x09, 0xFB, 0x0E, 0x02, 0x07, 0x05, 0x0D, 0x20. out_valid=1 throughout; zero=0.
- Extremes a=15, b=15 -> ADD 0x1E, MUL 0xE1, SUB 0x00 with zero=1, XOR 0x00 with zero=1, NOT 0x00 with zero=1.
- DIV: a=13, b=4 -> 0x13 (r=1, q=3). Then a=9, b=0 -> 0xFF, div_by_zero=1. Next a=9, b=3 DIV -> 0x03, div_by_zero=0.
- Handshake: in_valid pulse, idle 3 cycles -> out_valid high for exactly 1 cycle and out holds. rst asserted during idle -> out clears to 0.
- Random: 1000 random (sel, a, b) with random in_valid -> compare against the reference model with 1-cycle delay.
